// File: rtl/disp_pkg.sv
// Shared encodings for the display capture block and the display generator bench.
package disp_pkg;

    // Capture controller states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } cap_state_e;

    // Width of one packed RGB555 pixel.
    localparam int unsigned RGB555_W = 15;

    // True while a capture is in progress (armed, capturing or draining).
    function automatic logic st_busy(cap_state_e s);
        return (s == ST_WAIT_FRAME) || (s == ST_CAPTURE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/disp_capture_pix_fifo.sv
// Small synchronous FIFO with a registered show-ahead head; accepts a push when full if a pop happens too.
module pix_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             empty_q, empty_d;
    logic             pop_ok_c, push_ok_c;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = empty_q;
    assign head  = head_q;

    // Next pointers, occupancy and the value that will sit at the head after this edge.
    always_comb begin
        pop_ok_c  = pop && !empty_q;
        push_ok_c = push && (!full || pop_ok_c);
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_d    = head_q;

        if (push_ok_c) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok_c && !pop_ok_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_d = count_q - CW'(1);
        end

        empty_d = (count_d == CW'(0));
        if (!empty_d) begin
            // The new head is the incoming word only when it lands in the slot being read next.
            if (push_ok_c && (rd_ptr_d == wr_ptr_q)) begin
                head_d = din;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            empty_q  <= empty_d;
        end
    end

endmodule

// File: rtl/disp_capture.sv
// Captures one display frame on request and streams RGB pixel writes with linear addresses.
module disp_capture
    import disp_pkg::*;
#(
    parameter int unsigned BPC        = RGB555_W / 3,
    parameter int unsigned H_RES      = 672,
    parameter int unsigned V_RES      = 384,
    parameter int unsigned ADDRW      = 18,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic               arm,
    input  logic               disp_de,
    input  logic               disp_frame,
    input  logic [BPC-1:0]     disp_r,
    input  logic [BPC-1:0]     disp_g,
    input  logic [BPC-1:0]     disp_b,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDRW-1:0]   wr_addr,
    output logic [3*BPC-1:0]   wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               err_geom
);

    localparam int unsigned XW = $clog2(H_RES + 1);
    localparam int unsigned YW = $clog2(V_RES + 1);
    localparam int unsigned DW = 3 * BPC;
    localparam int unsigned FW = ADDRW + DW;

    cap_state_e       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             de_q, de_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             err_geom_q, err_geom_d;

    logic             fifo_full, fifo_empty;
    logic [FW-1:0]    fifo_head;
    logic [FW-1:0]    fifo_din_c;
    logic             push_c, pop_c, can_push_c;
    logic [YW-1:0]    y_inc_c;

    assign pop_c      = wr_ready && !fifo_empty;
    assign can_push_c = !fifo_full || pop_c;
    assign fifo_din_c = {addr_q, disp_r, disp_g, disp_b};
    assign y_inc_c    = y_q + YW'(1);

    assign wr_valid = !fifo_empty;
    assign wr_addr  = fifo_head[FW-1:DW];
    assign wr_data  = fifo_head[DW-1:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign err_geom = err_geom_q;

    // Output FIFO between the pixel stream and the write port.
    pix_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_pix),
        .rst_n (rst_pix_n),
        .push  (push_c),
        .din   (fifo_din_c),
        .pop   (pop_c),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Capture controller: next state, counters, sticky flags and FIFO push.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        de_d       = 1'b0;
        overflow_d = overflow_q;
        err_geom_d = err_geom_q;
        push_c     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    overflow_d = 1'b0;
                    err_geom_d = 1'b0;
                    state_d    = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (disp_frame) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                de_d = disp_de;
                if (disp_frame) begin
                    // New frame before all lines arrived: abandon and drain what we have.
                    err_geom_d = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (disp_de) begin
                    push_c = 1'b1;
                    if (!can_push_c) begin
                        overflow_d = 1'b1;
                    end
                    // Address advances even on a drop so later pixels land correctly.
                    addr_d = addr_q + ADDRW'(1);
                    if (x_q == XW'(H_RES)) begin
                        err_geom_d = 1'b1;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end else if (de_q) begin
                    if (x_q != XW'(H_RES)) begin
                        err_geom_d = 1'b1;
                    end
                    x_d = '0;
                    y_d = y_inc_c;
                    if (y_inc_c == YW'(V_RES)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = st_busy(state_d);
        done_d = (state_d == ST_DONE);
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            de_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            err_geom_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            de_q       <= de_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            err_geom_q <= err_geom_d;
        end
    end

endmodule
